vend_txn_ctrl: RTL and testbench
================================

VEND_TXN_CTRL -- requirements
Module: vend_txn_ctrl

Interface
REQ-001 SHALL have parameter PRICE_UNITS, default 6, meaning drink price in 5-cent units (1..CREDIT_MAX).
REQ-002 SHALL have parameter CREDIT_MAX, default 15, meaning maximum credit in 5-cent units (at most 15).
REQ-003 SHALL have parameter VEND_TIMEOUT, default 255, meaning cycles to wait for vend_ack before aborting (1..255).
REQ-004 SHALL use one clock and synchronous active-high reset, with ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  coin/cancel acceptance enable.
- nickel, dime, quarter  in  1 each  single-cycle coin pulses.
- cancel  in  1  refund request, one-cycle pulse.
- vend_req  out  1  dispense request, held until ack or timeout.
- vend_ack  in  1  dispenser accepted the request.
- vend_fail  out  1  one-cycle pulse on vend timeout.
- coin_valid  out  1  change coin offered.
- coin_type  out  2  offered coin: 01 nickel, 10 dime, 11 quarter, 00 none.
- coin_ready  in  1  change hopper accepts the offered coin.
- coin_reject  out  1  one-cycle pulse when an inserted coin is not credited.
- credit  out  4  current credit in 5-cent units.
- busy  out  1  high in any state other than IDLE/COLLECT.

Function
REQ-005 SHALL implement states IDLE (credit 0), COLLECT (0<credit<PRICE_UNITS), VEND, CHANGE.
REQ-006 SHALL credit a coin only in IDLE/COLLECT with en=1: nickel adds 1, dime adds 2, quarter adds 5; credit updates at the edge after the pulse.
REQ-007 SHALL reject, without changing credit, any cycle with more than one coin input high, or where credit+coin exceeds CREDIT_MAX.
REQ-008 SHALL also reject any coin pulse seen in VEND or CHANGE, or while en=0; each rejection produces a one-cycle coin_reject pulse on the following cycle.
REQ-009 SHALL enter VEND at the edge where the new credit is at least PRICE_UNITS, asserting vend_req from that cycle.
REQ-010 SHALL, in VEND, on vend_ack=1 deassert vend_req next cycle and subtract PRICE_UNITS from credit; next state is CHANGE if the remainder is >0, else IDLE.
REQ-011 SHALL count VEND cycles; after VEND_TIMEOUT cycles without ack, pulse vend_fail, drop vend_req, keep full credit and enter CHANGE (refund).
REQ-012 SHALL treat cancel as follows: with en=1 in COLLECT, enter CHANGE with full credit; in IDLE, VEND or CHANGE, ignore it.
REQ-013 SHALL give cancel priority over a same-cycle coin, and reject that coin.
REQ-014 SHALL, in CHANGE, assert coin_valid with coin_type set to the largest coin not exceeding credit (quarter if at least 5, dime if at least 2, else nickel).
REQ-015 SHALL hold coin_valid and coin_type stable while coin_ready=0.
REQ-016 SHALL, on coin_valid&coin_ready, subtract the coin value at that edge; if credit reaches 0, enter IDLE with coin_valid=0 and coin_type=00 next cycle, else offer the next coin next cycle.
REQ-017 SHALL drive coin_type=00 whenever coin_valid=0.
REQ-018 SHALL register all outputs, with no combinational input-to-output paths.

Reset
REQ-019 SHALL, on rst=1 at a clock edge, regardless of state (including mid-VEND and mid-CHANGE), set state IDLE and credit 0, and clear the timeout counter, vend_req, vend_fail, coin_valid, coin_type (00), coin_reject and busy.
REQ-020 SHALL drop any offered coin or pending vend on reset without completing its handshake.

Structure
REQ-021 SHALL place coin encodings, coin unit values and the state enumeration in shared package vend_pkg.
REQ-022 SHALL implement largest-coin selection in sub-module change_coin_select (credit in, coin_type and value out, combinational).

Verification (PRICE_UNITS=6 unless stated)
REQ-023 SHALL cover exact payment: quarter then nickel -> credit 5 then 6, vend_req next cycle, ack -> credit 0, IDLE, no coin_valid.
REQ-024 SHALL cover overpayment: quarter, quarter -> credit 10, VEND, ack -> credit 4, change dime then dime with coin_ready stalled 3 cycles on the first, then IDLE.
REQ-025 SHALL cover refund: dime then cancel -> CHANGE, one dime offered, credit 0 after handshake; a nickel during CHANGE -> coin_reject pulse.
REQ-026 SHALL cover illegal coins: nickel+dime in the same cycle -> coin_reject, credit unchanged; with PRICE_UNITS=15 at credit 11, quarter -> coin_reject, credit stays 11.
REQ-027 SHALL cover vend timeout: with VEND_TIMEOUT=4 and credit 7, no ack -> vend_fail after 4 VEND cycles, refund quarter then dime.
REQ-028 SHALL cover reset mid-operation: rst during CHANGE with coin_valid=1 -> all outputs zero at the next edge, and a subsequent nickel credits 1.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared definitions for the vending transaction controller:
// state enumeration, change-coin encodings and coin unit values.
package vend_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_VEND    = 2'd2,
      ST_CHANGE  = 2'd3
   } vend_state_t;

   localparam logic [1:0] COIN_NONE    = 2'b00;
   localparam logic [1:0] COIN_NICKEL  = 2'b01;
   localparam logic [1:0] COIN_DIME    = 2'b10;
   localparam logic [1:0] COIN_QUARTER = 2'b11;

   localparam logic [3:0] NICKEL_UNITS  = 4'd1;
   localparam logic [3:0] DIME_UNITS    = 4'd2;
   localparam logic [3:0] QUARTER_UNITS = 4'd5;

endpackage

// File: rtl/change_coin_select.sv
// Picks the largest change coin that does not exceed the given credit.
module change_coin_select
   import vend_pkg::*;
(
   input  logic [3:0] credit,
   output logic [1:0] coin_type,
   output logic [3:0] value
);

   // Largest-coin-first selection; a zero credit defaults to a nickel.
   always_comb begin
      coin_type = COIN_NICKEL;
      value     = NICKEL_UNITS;
      if (credit >= QUARTER_UNITS) begin
         coin_type = COIN_QUARTER;
         value     = QUARTER_UNITS;
      end else if (credit >= DIME_UNITS) begin
         coin_type = COIN_DIME;
         value     = DIME_UNITS;
      end
   end

endmodule

// File: rtl/vend_txn_ctrl.sv
// Vending transaction controller: collects coins, requests a vend,
// handles vend timeout and pays change one coin at a time.
module vend_txn_ctrl
   import vend_pkg::*;
#(
   parameter int unsigned PRICE_UNITS  = 6,
   parameter int unsigned CREDIT_MAX   = 15,
   parameter int unsigned VEND_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       nickel,
   input  logic       dime,
   input  logic       quarter,
   input  logic       cancel,
   output logic       vend_req,
   input  logic       vend_ack,
   output logic       vend_fail,
   output logic       coin_valid,
   output logic [1:0] coin_type,
   input  logic       coin_ready,
   output logic       coin_reject,
   output logic [3:0] credit,
   output logic       busy
);

   localparam logic [3:0] PRICE    = 4'(PRICE_UNITS);
   localparam logic [4:0] CMAX     = 5'(CREDIT_MAX);
   localparam logic [7:0] TO_LAST  = 8'(VEND_TIMEOUT - 1);

   vend_state_t state, state_n;
   logic [3:0]  credit_n;
   logic [7:0]  cnt, cnt_n;
   logic        vend_req_n, vend_fail_n, reject_n, busy_n;
   logic        coin_valid_n;
   logic [1:0]  coin_type_n;
   logic [3:0]  coin_val_q, coin_val_n;
   logic        offer, offer_clr;
   logic [1:0]  sel_type;
   logic [3:0]  sel_val;
   logic [1:0]  coin_cnt;
   logic [4:0]  coin_units;
   logic [4:0]  sum;
   logic        cancel_go;

   change_coin_select u_sel (
      .credit    (credit_n),
      .coin_type (sel_type),
      .value     (sel_val)
   );

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         credit      <= '0;
         cnt         <= '0;
         vend_req    <= 1'b0;
         vend_fail   <= 1'b0;
         coin_valid  <= 1'b0;
         coin_type   <= COIN_NONE;
         coin_val_q  <= '0;
         coin_reject <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_n;
         credit      <= credit_n;
         cnt         <= cnt_n;
         vend_req    <= vend_req_n;
         vend_fail   <= vend_fail_n;
         coin_valid  <= coin_valid_n;
         coin_type   <= coin_type_n;
         coin_val_q  <= coin_val_n;
         coin_reject <= reject_n;
         busy        <= busy_n;
      end
   end

   // Next state, credit arithmetic and one-cycle pulse generation.
   always_comb begin
      state_n     = state;
      credit_n    = credit;
      cnt_n       = cnt;
      vend_req_n  = vend_req;
      vend_fail_n = 1'b0;
      reject_n    = 1'b0;
      offer       = 1'b0;
      offer_clr   = 1'b0;
      cancel_go   = 1'b0;
      coin_cnt    = 2'(nickel) + 2'(dime) + 2'(quarter);
      coin_units  = nickel ? 5'(NICKEL_UNITS) :
                    dime   ? 5'(DIME_UNITS)   :
                    quarter ? 5'(QUARTER_UNITS) : 5'd0;
      sum         = {1'b0, credit} + coin_units;

      case (state)
         ST_IDLE, ST_COLLECT: begin
            cancel_go = en && cancel && (state == ST_COLLECT);
            if (coin_cnt != 2'd0) begin
               if (cancel_go || !en || coin_cnt > 2'd1 || sum > CMAX)
                  reject_n = 1'b1;
               else
                  credit_n = sum[3:0];
            end
            if (cancel_go) begin
               state_n = ST_CHANGE;
               offer   = 1'b1;
            end else if (credit_n >= PRICE) begin
               state_n    = ST_VEND;
               vend_req_n = 1'b1;
               cnt_n      = '0;
            end else if (credit_n != 4'd0) begin
               state_n = ST_COLLECT;
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_VEND: begin
            if (coin_cnt != 2'd0) reject_n = 1'b1;
            if (vend_ack) begin
               vend_req_n = 1'b0;
               credit_n   = credit - PRICE;
               if (credit_n != 4'd0) begin
                  state_n = ST_CHANGE;
                  offer   = 1'b1;
               end else begin
                  state_n = ST_IDLE;
               end
            end else if (cnt == TO_LAST) begin
               vend_fail_n = 1'b1;
               vend_req_n  = 1'b0;
               state_n     = ST_CHANGE;
               offer       = 1'b1;
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         ST_CHANGE: begin
            if (coin_cnt != 2'd0) reject_n = 1'b1;
            if (coin_valid && coin_ready) begin
               credit_n = credit - coin_val_q;
               if (credit_n == 4'd0) begin
                  state_n   = ST_IDLE;
                  offer_clr = 1'b1;
               end else begin
                  offer = 1'b1;
               end
            end
         end
         default: state_n = ST_IDLE;
      endcase

      busy_n = (state_n == ST_VEND) || (state_n == ST_CHANGE);
   end

   // Change-coin offer registers; selection is driven from the next credit
   // in a separate process so the selector sits outside the FSM loop.
   always_comb begin
      coin_valid_n = coin_valid;
      coin_type_n  = coin_type;
      coin_val_n   = coin_val_q;
      if (offer) begin
         coin_valid_n = 1'b1;
         coin_type_n  = sel_type;
         coin_val_n   = sel_val;
      end else if (offer_clr) begin
         coin_valid_n = 1'b0;
         coin_type_n  = COIN_NONE;
         coin_val_n   = '0;
      end
   end

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Self-checking bench: three controller configurations share one stimulus
// stream and are compared every cycle against a transaction-level model,
// plus directed checks with hand-derived values.
module tb_vend_txn_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1, en = 1'b1;
   logic nickel = 1'b0, dime = 1'b0, quarter = 1'b0, cancel = 1'b0;
   logic vend_ack = 1'b0, coin_ready = 1'b0;

   logic       vend_req_o[3];
   logic       vend_fail_o[3];
   logic       coin_valid_o[3];
   logic [1:0] coin_type_o[3];
   logic       coin_reject_o[3];
   logic [3:0] credit_o[3];
   logic       busy_o[3];

   int checks = 0;
   int errors = 0;

   // 0: defaults, 1: price 15, 2: timeout 4
   int price[3] = '{6, 15, 6};
   int tmo[3]   = '{255, 255, 4};

   vend_txn_ctrl u_def (
      .clk(clk), .rst(rst), .en(en), .nickel(nickel), .dime(dime),
      .quarter(quarter), .cancel(cancel), .vend_req(vend_req_o[0]),
      .vend_ack(vend_ack), .vend_fail(vend_fail_o[0]),
      .coin_valid(coin_valid_o[0]), .coin_type(coin_type_o[0]),
      .coin_ready(coin_ready), .coin_reject(coin_reject_o[0]),
      .credit(credit_o[0]), .busy(busy_o[0]));

   vend_txn_ctrl #(.PRICE_UNITS(15)) u_p15 (
      .clk(clk), .rst(rst), .en(en), .nickel(nickel), .dime(dime),
      .quarter(quarter), .cancel(cancel), .vend_req(vend_req_o[1]),
      .vend_ack(vend_ack), .vend_fail(vend_fail_o[1]),
      .coin_valid(coin_valid_o[1]), .coin_type(coin_type_o[1]),
      .coin_ready(coin_ready), .coin_reject(coin_reject_o[1]),
      .credit(credit_o[1]), .busy(busy_o[1]));

   vend_txn_ctrl #(.VEND_TIMEOUT(4)) u_to (
      .clk(clk), .rst(rst), .en(en), .nickel(nickel), .dime(dime),
      .quarter(quarter), .cancel(cancel), .vend_req(vend_req_o[2]),
      .vend_ack(vend_ack), .vend_fail(vend_fail_o[2]),
      .coin_valid(coin_valid_o[2]), .coin_type(coin_type_o[2]),
      .coin_ready(coin_ready), .coin_reject(coin_reject_o[2]),
      .credit(credit_o[2]), .busy(busy_o[2]));

   typedef struct {
      int credit;
      bit vending;
      bit refunding;
      int waited;
      bit vreq;
      bit vfail;
      bit cvalid;
      int ctype;
      bit crej;
   } mstate_t;

   mstate_t m[3];
   mstate_t nxt[3];

   function automatic int largest_coin(int c);
      if (c >= 5) return 3;
      if (c >= 2) return 2;
      return 1;
   endfunction

   function automatic int coin_value(int t);
      if (t == 3) return 5;
      if (t == 2) return 2;
      return 1;
   endfunction

   function automatic mstate_t mstep(mstate_t s, int p, int to, bit r, bit e,
                                     bit n, bit d, bit q, bit c, bit a, bit rd);
      mstate_t o;
      int coins, val;
      bit cancel_ok;
      o = s;
      if (r) begin
         o.credit = 0; o.vending = 0; o.refunding = 0; o.waited = 0;
         o.vreq = 0; o.vfail = 0; o.cvalid = 0; o.ctype = 0; o.crej = 0;
         return o;
      end
      o.vfail = 0;
      o.crej  = 0;
      coins = int'(n) + int'(d) + int'(q);
      val   = n ? 1 : d ? 2 : q ? 5 : 0;
      if (s.vending) begin
         if (coins > 0) o.crej = 1;
         if (a) begin
            o.credit = s.credit - p;
            o.vending = 0;
            o.vreq = 0;
            if (o.credit > 0) begin
               o.refunding = 1; o.cvalid = 1; o.ctype = largest_coin(o.credit);
            end
         end else if (s.waited + 1 >= to) begin
            o.vfail = 1; o.vreq = 0; o.vending = 0; o.refunding = 1;
            o.cvalid = 1; o.ctype = largest_coin(s.credit);
         end else begin
            o.waited = s.waited + 1;
         end
      end else if (s.refunding) begin
         if (coins > 0) o.crej = 1;
         if (rd) begin
            o.credit = s.credit - coin_value(s.ctype);
            if (o.credit == 0) begin
               o.refunding = 0; o.cvalid = 0; o.ctype = 0;
            end else begin
               o.ctype = largest_coin(o.credit);
            end
         end
      end else begin
         cancel_ok = e && c && (s.credit > 0);
         if (coins > 0) begin
            if (cancel_ok || !e || coins > 1 || s.credit + val > 15) o.crej = 1;
            else o.credit = s.credit + val;
         end
         if (cancel_ok) begin
            o.refunding = 1; o.cvalid = 1; o.ctype = largest_coin(o.credit);
         end else if (o.credit >= p) begin
            o.vending = 1; o.vreq = 1; o.waited = 0;
         end
      end
      return o;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cmp_all();
      for (int k = 0; k < 3; k++) begin
         check($sformatf("u%0d_credit", k), 32'(credit_o[k]), 32'(m[k].credit));
         check($sformatf("u%0d_vend_req", k), 32'(vend_req_o[k]), 32'(m[k].vreq));
         check($sformatf("u%0d_vend_fail", k), 32'(vend_fail_o[k]), 32'(m[k].vfail));
         check($sformatf("u%0d_coin_valid", k), 32'(coin_valid_o[k]), 32'(m[k].cvalid));
         check($sformatf("u%0d_coin_type", k), 32'(coin_type_o[k]), 32'(m[k].ctype));
         check($sformatf("u%0d_coin_reject", k), 32'(coin_reject_o[k]), 32'(m[k].crej));
         check($sformatf("u%0d_busy", k), 32'(busy_o[k]),
               32'(m[k].vending || m[k].refunding));
      end
   endtask

   task automatic cyc(input bit n, input bit d, input bit q, input bit c,
                      input bit a, input bit rd);
      nickel = n; dime = d; quarter = q; cancel = c;
      vend_ack = a; coin_ready = rd;
      for (int k = 0; k < 3; k++)
         nxt[k] = mstep(m[k], price[k], tmo[k], rst, en, n, d, q, c, a, rd);
      @(posedge clk);
      #1;
      m = nxt;
      cmp_all();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(0, 0, 0, 0, 0, 0);
      rst = 1'b0;
   endtask

   initial begin
      int r;
      bit rn, rdm, rq;

      // Reset state
      do_reset();
      check("rst_credit", 32'(credit_o[0]), 0);
      check("rst_busy", 32'(busy_o[0]), 0);
      check("rst_coin_type", 32'(coin_type_o[0]), 0);

      // Exact payment: quarter, nickel, ack
      cyc(0, 0, 1, 0, 0, 0);
      check("exact_credit5", 32'(credit_o[0]), 5);
      check("exact_noreq", 32'(vend_req_o[0]), 0);
      cyc(1, 0, 0, 0, 0, 0);
      check("exact_credit6", 32'(credit_o[0]), 6);
      check("exact_req", 32'(vend_req_o[0]), 1);
      cyc(0, 0, 0, 0, 1, 0);
      check("exact_done_credit", 32'(credit_o[0]), 0);
      check("exact_done_req", 32'(vend_req_o[0]), 0);
      check("exact_done_cvalid", 32'(coin_valid_o[0]), 0);

      // Overpayment with stalled change hopper
      do_reset();
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0);
      check("over_credit10", 32'(credit_o[0]), 10);
      check("over_req", 32'(vend_req_o[0]), 1);
      cyc(0, 0, 0, 0, 1, 0);
      check("over_credit4", 32'(credit_o[0]), 4);
      check("over_coin1", 32'(coin_type_o[0]), 2);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 0, 0, 0);
         check("over_stall_valid", 32'(coin_valid_o[0]), 1);
         check("over_stall_type", 32'(coin_type_o[0]), 2);
      end
      cyc(0, 0, 0, 0, 0, 1);
      check("over_credit2", 32'(credit_o[0]), 2);
      check("over_coin2", 32'(coin_type_o[0]), 2);
      cyc(0, 0, 0, 0, 0, 1);
      check("over_end_credit", 32'(credit_o[0]), 0);
      check("over_end_valid", 32'(coin_valid_o[0]), 0);
      check("over_end_busy", 32'(busy_o[0]), 0);

      // Refund via cancel, coin during change rejected
      do_reset();
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0);
      check("refund_valid", 32'(coin_valid_o[0]), 1);
      check("refund_type", 32'(coin_type_o[0]), 2);
      cyc(1, 0, 0, 0, 0, 0);
      check("refund_reject", 32'(coin_reject_o[0]), 1);
      check("refund_credit_kept", 32'(credit_o[0]), 2);
      cyc(0, 0, 0, 0, 0, 1);
      check("refund_credit0", 32'(credit_o[0]), 0);
      check("refund_reject_pulse", 32'(coin_reject_o[0]), 0);

      // Illegal coins: two at once, and overflow at price 15
      do_reset();
      cyc(1, 1, 0, 0, 0, 0);
      check("multi_reject", 32'(coin_reject_o[0]), 1);
      check("multi_credit", 32'(credit_o[0]), 0);
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      check("p15_credit11", 32'(credit_o[1]), 11);
      cyc(0, 0, 1, 0, 0, 0);
      check("p15_reject", 32'(coin_reject_o[1]), 1);
      check("p15_credit_kept", 32'(credit_o[1]), 11);

      // Coin while disabled
      do_reset();
      en = 1'b0;
      cyc(1, 0, 0, 0, 0, 0);
      check("dis_reject", 32'(coin_reject_o[0]), 1);
      check("dis_credit", 32'(credit_o[0]), 0);
      en = 1'b1;

      // Vend timeout at VEND_TIMEOUT=4 with credit 7
      do_reset();
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      check("to_credit7", 32'(credit_o[2]), 7);
      check("to_req", 32'(vend_req_o[2]), 1);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 0, 0, 0);
         check("to_wait_req", 32'(vend_req_o[2]), 1);
         check("to_wait_fail", 32'(vend_fail_o[2]), 0);
      end
      cyc(0, 0, 0, 0, 0, 0);
      check("to_fail", 32'(vend_fail_o[2]), 1);
      check("to_req_drop", 32'(vend_req_o[2]), 0);
      check("to_credit_kept", 32'(credit_o[2]), 7);
      check("to_coin1", 32'(coin_type_o[2]), 3);
      cyc(0, 0, 0, 0, 0, 1);
      check("to_fail_pulse", 32'(vend_fail_o[2]), 0);
      check("to_coin2", 32'(coin_type_o[2]), 2);
      cyc(0, 0, 0, 0, 0, 1);
      check("to_end_credit", 32'(credit_o[2]), 0);

      // Reset during change
      do_reset();
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0);
      check("mid_valid", 32'(coin_valid_o[0]), 1);
      rst = 1'b1;
      cyc(0, 0, 0, 0, 0, 1);
      rst = 1'b0;
      check("mid_rst_valid", 32'(coin_valid_o[0]), 0);
      check("mid_rst_credit", 32'(credit_o[0]), 0);
      check("mid_rst_busy", 32'(busy_o[0]), 0);
      cyc(1, 0, 0, 0, 0, 0);
      check("mid_nickel", 32'(credit_o[0]), 1);

      // Randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         rst = ($urandom_range(0, 99) == 0);
         en  = ($urandom_range(0, 9) != 0);
         r = $urandom_range(0, 15);
         rn  = (r == 0) || (r == 3);
         rdm = (r == 1) || (r == 3) || (r == 4);
         rq  = (r == 2) || (r == 4);
         cyc(rn, rdm, rq, ($urandom_range(0, 11) == 0),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
      end
      rst = 1'b0;
      en  = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
